// File: rtl/rs_issue_select.sv
// rs_issue_select: issue scheduler for a 16-entry reservation station.
// Each cycle it picks up to WAYS ready entries in round-robin order,
// starting at rr_ptr, and places them in the free issue lanes. Each lane
// holds its entry until the FU accepts it. Accepted entries are reported
// to the RS through a one-hot clear mask.
module rs_issue_select #(
  parameter int RS    = 16,
  parameter int WAYS  = 3,
  parameter int IDX_W = $clog2(RS),
  parameter int CNT_W = $clog2(WAYS+1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [RS-1:0]         ready_vec,
  input  logic                  squash,
  input  logic [WAYS-1:0]       fu_ready,
  output logic [WAYS-1:0]       issue_valid,
  output logic [WAYS*IDX_W-1:0] issue_idx,
  output logic [RS-1:0]         clear_vec,
  output logic [CNT_W-1:0]      num_accepted,
  output logic [IDX_W-1:0]      rr_ptr
);

  logic [IDX_W-1:0] lane_idx [WAYS];
  logic [IDX_W-1:0] fill_idx [WAYS];
  logic [WAYS-1:0]  accept;
  logic [WAYS-1:0]  avail;
  logic [WAYS-1:0]  fill;
  logic [RS-1:0]    pending;
  logic [RS-1:0]    cand;
  logic             grant_any;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] scan_e;
  logic             placed;

  // Flatten the per-lane index registers onto the packed output bus.
  always_comb begin
    issue_idx = '0;
    for (int l = 0; l < WAYS; l++)
      issue_idx[l*IDX_W +: IDX_W] = lane_idx[l];
  end

  // Accepted lanes produce the clear mask and the accept count.
  // Reset and squash suppress both: the RS flushes itself in those cases.
  always_comb begin
    accept       = issue_valid & fu_ready & {WAYS{reset & ~squash}};
    clear_vec    = '0;
    num_accepted = '0;
    for (int l = 0; l < WAYS; l++) begin
      if (accept[l]) begin
        clear_vec[lane_idx[l]] = 1'b1;
        num_accepted           = num_accepted + 1'b1;
      end
    end
  end

  // Build the candidate set. Lanes being accepted this cycle still count as
  // pending, because the RS only frees those entries at the next edge.
  always_comb begin
    pending = '0;
    for (int l = 0; l < WAYS; l++)
      if (issue_valid[l]) pending[lane_idx[l]] = 1'b1;
    cand  = ready_vec & ~pending;
    avail = ~issue_valid | fu_ready;
  end

  // Round-robin scan from rr_ptr. Each candidate found goes to the lowest
  // available lane that is still unfilled. Once every lane is filled, the
  // remaining candidates are skipped.
  always_comb begin
    fill       = '0;
    grant_any  = 1'b0;
    last_grant = rr_ptr;
    scan_e     = '0;
    placed     = 1'b0;
    for (int l = 0; l < WAYS; l++) fill_idx[l] = '0;
    for (int j = 0; j < RS; j++) begin
      scan_e = rr_ptr + IDX_W'(j);
      placed = 1'b0;
      if (cand[scan_e]) begin
        for (int l = 0; l < WAYS; l++) begin
          if (!placed && avail[l] && !fill[l]) begin
            fill[l]     = 1'b1;
            fill_idx[l] = scan_e;
            placed      = 1'b1;
            grant_any   = 1'b1;
            last_grant  = scan_e;
          end
        end
      end
    end
  end

  // Lane registers and the priority pointer. Reset takes precedence over
  // squash. A squash empties all lanes but leaves the pointer where it is.
  always_ff @(posedge clock) begin
    if (!reset) begin
      issue_valid <= '0;
      rr_ptr      <= '0;
      for (int l = 0; l < WAYS; l++) lane_idx[l] <= '0;
    end else if (squash) begin
      issue_valid <= '0;
    end else begin
      for (int l = 0; l < WAYS; l++) begin
        if (avail[l]) begin
          issue_valid[l] <= fill[l];
          if (fill[l]) lane_idx[l] <= fill_idx[l];
        end
      end
      if (grant_any) rr_ptr <= last_grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Testbench for rs_issue_select. Stimulus first runs the directed scenarios
// and then random traffic. A list-based reference model pushes the expected
// per-cycle outputs into a queue. A negedge monitor pops each entry and
// compares it with the DUT outputs.
module tb_rs_issue_select;

  localparam int RS = 16;
  localparam int WAYS = 3;

  logic        clock;
  logic        reset;
  logic [15:0] ready_vec;
  logic        squash;
  logic [2:0]  fu_ready;
  logic [2:0]  issue_valid;
  logic [11:0] issue_idx;
  logic [15:0] clear_vec;
  logic [1:0]  num_accepted;
  logic [3:0]  rr_ptr;

  rs_issue_select dut (
    .clock(clock), .reset(reset), .ready_vec(ready_vec), .squash(squash),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .clear_vec(clear_vec), .num_accepted(num_accepted), .rr_ptr(rr_ptr)
  );

  typedef struct {
    bit          known;
    logic [2:0]  v;
    logic [11:0] idx;
    logic [3:0]  ptr;
    logic [15:0] clr;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: lane contents as plain integers.
  bit mv[WAYS];
  int mi[WAYS];
  int mp;
  bit known;

  int checks = 0;
  int errors = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Drive one cycle, record its expected outputs, then advance the model.
  task automatic step(input bit rst, input bit sq, input logic [15:0] rdy, input logic [2:0] fu);
    exp_t x;
    int cq[$];
    int aq[$];
    bit pend[RS];
    int last;
    reset = rst; squash = sq; ready_vec = rdy; fu_ready = fu;
    x.known = known;
    x.v = '0; x.idx = '0; x.clr = '0; x.cnt = '0;
    x.ptr = mp[3:0];
    for (int l = 0; l < WAYS; l++) begin
      x.v[l] = mv[l];
      x.idx[l*4 +: 4] = mi[l][3:0];
      if (rst && !sq && mv[l] && fu[l]) begin
        x.clr[mi[l]] = 1'b1;
        x.cnt = x.cnt + 2'd1;
      end
    end
    exp_q.push_back(x);
    if (!rst) begin
      for (int l = 0; l < WAYS; l++) begin mv[l] = 0; mi[l] = 0; end
      mp = 0;
      known = 1;
    end else if (sq) begin
      for (int l = 0; l < WAYS; l++) mv[l] = 0;
    end else begin
      for (int e = 0; e < RS; e++) pend[e] = 0;
      for (int l = 0; l < WAYS; l++) if (mv[l]) pend[mi[l]] = 1;
      for (int j = 0; j < RS; j++) begin
        int e;
        e = (mp + j) % RS;
        if (rdy[e] && !pend[e]) cq.push_back(e);
      end
      for (int l = 0; l < WAYS; l++) if (!mv[l] || fu[l]) aq.push_back(l);
      last = -1;
      for (int k = 0; k < aq.size(); k++) begin
        if (k < cq.size()) begin
          mv[aq[k]] = 1; mi[aq[k]] = cq[k]; last = cq[k];
        end else begin
          mv[aq[k]] = 0;
        end
      end
      if (last >= 0) mp = (last + 1) % RS;
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      int dup;
      x = exp_q.pop_front();
      if (x.known) begin
        chk("issue_valid", {29'd0, issue_valid}, {29'd0, x.v});
        for (int l = 0; l < WAYS; l++)
          if (x.v[l]) chk($sformatf("issue_idx[%0d]", l), {28'd0, issue_idx[l*4 +: 4]}, {28'd0, x.idx[l*4 +: 4]});
        chk("rr_ptr", {28'd0, rr_ptr}, {28'd0, x.ptr});
        dup = 0;
        for (int a = 0; a < WAYS; a++)
          for (int b = a + 1; b < WAYS; b++)
            if (issue_valid[a] && issue_valid[b] && issue_idx[a*4 +: 4] == issue_idx[b*4 +: 4]) dup++;
        chk("no_duplicate_lane", dup, 0);
      end
      chk("clear_vec", {16'd0, clear_vec}, {16'd0, x.clr});
      chk("num_accepted", {30'd0, num_accepted}, {30'd0, x.cnt});
    end
  end

  initial begin
    known = 0; mp = 0;
    for (int l = 0; l < WAYS; l++) begin mv[l] = 0; mi[l] = 0; end
    reset = 0; squash = 0; ready_vec = '0; fu_ready = '0;
    @(posedge clock);
    #1;

    // Reset and fill.
    step(0, 0, 16'h0000, 3'b000);
    step(0, 0, 16'h0000, 3'b000);
    step(1, 0, 16'h00F0, 3'b111);
    chk("fill_valid", {29'd0, issue_valid}, 32'h7);
    chk("fill_idx", {20'd0, issue_idx}, 32'h654);
    chk("fill_ptr", {28'd0, rr_ptr}, 32'd7);
    step(1, 0, 16'h00F0, 3'b111);
    chk("fill2_valid", {29'd0, issue_valid}, 32'h1);
    chk("fill2_idx0", {28'd0, issue_idx[3:0]}, 32'd7);

    // Wrap-around from rr_ptr = 14.
    step(0, 0, 16'h0000, 3'b000);
    step(1, 0, 16'h2000, 3'b111);
    chk("wrap_setup_ptr", {28'd0, rr_ptr}, 32'd14);
    step(1, 0, 16'hC003, 3'b111);
    chk("wrap_idx", {20'd0, issue_idx}, 32'h0FE);
    chk("wrap_ptr", {28'd0, rr_ptr}, 32'd1);

    // Stall with lanes holding {2,3,4}.
    step(0, 0, 16'h0000, 3'b000);
    step(1, 0, 16'h001C, 3'b111);
    step(1, 0, 16'h003C, 3'b010);
    chk("stall_idx", {20'd0, issue_idx}, 32'h452);
    chk("stall_valid", {29'd0, issue_valid}, 32'h7);

    // Squash while every lane is valid.
    step(1, 1, 16'hFFFF, 3'b111);
    chk("squash_valid", {29'd0, issue_valid}, 32'h0);
    chk("squash_ptr", {28'd0, rr_ptr}, 32'd6);

    // Round-robin fairness.
    step(0, 0, 16'h0000, 3'b000);
    for (int c = 0; c < 6; c++) step(1, 0, 16'hFFFF, 3'b111);

    // Reset in mid-operation.
    step(0, 0, 16'hFFFF, 3'b111);
    step(1, 0, 16'h0000, 3'b111);

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      step($urandom_range(63) != 0, $urandom_range(15) == 0,
           16'($urandom), 3'($urandom_range(7)));
    step(1, 0, 16'h0000, 3'b111);

    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue scheduler for the 16-entry reservation station.
- Each cycle it picks up to WAYS ready RS entries with rotating (round-robin) priority and assigns them to free issue lanes.
- Picked entries are held in registered per-lane issue slots until the downstream functional unit accepts them.
- On acceptance, the block returns a one-hot clear mask that tells the RS which entries to free.

Parameters:
- RS, 16, number of reservation-station entries.
- WAYS, 3, number of issue lanes.
- IDX_W, $clog2(RS), entry index width.
- CNT_W, $clog2(WAYS+1), accept-count width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- ready_vec  in  RS  bit i = RS entry i valid and both operands ready.
- squash  in  1  pipeline flush (branch mispredict).
- fu_ready  in  WAYS  lane l FU accepts the held instruction this cycle.
- issue_valid  out  WAYS  lane l holds an instruction to issue.
- issue_idx  out  WAYS*IDX_W  RS entry index held in lane l.
- clear_vec  out  RS  one-hot-per-accept mask; RS frees entry i at the next edge.
- num_accepted  out  CNT_W  number of lanes accepted this cycle.
- rr_ptr  out  IDX_W  current priority start pointer (debug/verification).

Behaviour:
- Reset (reset==0 at a clock edge): issue_valid=0, issue_idx=0 (all lanes), rr_ptr=0.
- Reset is combinational-gated: while reset==0, clear_vec=0 and num_accepted=0.
- Reset applied mid-operation discards held lanes; no clear_vec pulse is produced for them.
- Accept: lane l is accepted when issue_valid[l] && fu_ready[l].
  - clear_vec[issue_idx[l]]=1 for each accepted lane.
  - num_accepted = popcount of accepted lanes.
  - Both outputs are combinational from the lane registers and fu_ready.
- Stall: issue_valid[l] && !fu_ready[l] means lane l holds issue_idx[l] unchanged.
- Available lane: !issue_valid[l] || fu_ready[l].
- Pending mask: the set of issue_idx[l] for every lane with issue_valid[l], including lanes being accepted this cycle (RS clears them only at the next edge).
- Candidates: ready_vec & ~pending. An entry is never in two lanes, and a held entry is never re-picked.
- Selection:
  - Scan candidates from entry rr_ptr upward, wrapping RS-1 -> 0.
  - The k-th candidate found goes to the k-th available lane in ascending lane order.
  - Stop when candidates or available lanes are exhausted.
- Registered update at the next edge:
  - A filled lane gets issue_valid=1 and issue_idx=entry.
  - An available lane left unfilled gets issue_valid=0.
- Latency: ready_vec bit high in cycle N -> issue_valid in cycle N+1 (if a lane is available and the entry wins priority).
  - Earliest clear_vec for that entry is cycle N+1 (when fu_ready=1).
- rr_ptr update:
  - If >=1 grant: rr_ptr <= (last granted entry index + 1) mod RS.
  - Else: unchanged.
  - All index arithmetic is modulo RS, with RS a power of two.
- Squash (squash==1 at an edge): all issue_valid <= 0, no new grants, rr_ptr unchanged.
  - In the squash cycle clear_vec=0 and num_accepted=0; the RS flushes itself.
- Squash and reset together: reset wins.
- All lanes stalled: no grants, rr_ptr unchanged, ready entries wait.
- ready_vec all zero: available lanes drain to invalid.
- ready_vec may drop a bit for an entry already held in a lane; the lane still holds it. The RS guarantees held entries stay valid until cleared or squashed.

Test Plan:
- Reset and fill:
  - Stimulus: reset=0 for 2 cycles, then reset=1, ready_vec=16'h00F0, fu_ready=3'b111.
  - Required: cycle 1 issue_valid=3'b111, idx={4,5,6} on lanes 0,1,2, rr_ptr=7.
  - Required: next cycle lane0 idx=7, other lanes invalid, clear_vec=16'h0070, num_accepted=3.
- Wrap-around:
  - Stimulus: rr_ptr=14, ready_vec=16'hC003.
  - Required: lanes get idx 14,15,0; rr_ptr becomes 1.
- Stall:
  - Stimulus: lanes hold {2,3,4}, fu_ready=3'b010, ready_vec=16'h003C.
  - Required: clear_vec=16'h0008, num_accepted=1.
  - Required: next cycle lane1 idx=5 (2 and 4 masked as pending), lanes 0 and 2 unchanged.
- Squash:
  - Stimulus: lanes valid, squash=1, fu_ready=3'b111.
  - Required: clear_vec=0 that cycle; next cycle issue_valid=0; rr_ptr unchanged.
- Round-robin fairness:
  - Stimulus: ready_vec=16'hFFFF held for 6 cycles, fu_ready=3'b111.
  - Required: issued idx sequence 0..15 then 0,1 with no repeats before wrap; no entry ever in two lanes.
- Reset mid-operation:
  - Stimulus: lanes valid with fu_ready=3'b111, reset=0.
  - Required: clear_vec=0; next cycle issue_valid=0, rr_ptr=0.
